// File: rtl/gauss3x3_stream.sv
// Streaming 3x3 Gaussian smoother [1 2 1; 2 4 2; 1 2 1] with edge replication.
// Two line buffers feed a column-sum window; the last image row is flushed internally.
module gauss3x3_stream #(
  parameter int W = 430,
  parameter int H = 554
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pixel_in,
  input  logic       vld_in,
  output logic [7:0] pixel_out,
  output logic       vld_out,
  output logic       frame_done,
  output logic       busy,
  output logic       ovf
);

  localparam int XW = (W > 1) ? $clog2(W) : 1;
  localparam int YW = (H > 1) ? $clog2(H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(H - 1);
  localparam logic [XW-1:0] X_ZERO = XW'(0);
  localparam logic [YW-1:0] Y_ZERO = YW'(0);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);

  typedef enum logic [1:0] {ST_FILL = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2} state_t;

  state_t          r_state;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;

  logic [7:0]      r_s1_pix;
  logic [XW-1:0]   r_s1_x;
  logic            r_s1_wr, r_s1_col, r_s1_emit, r_s1_right, r_s1_final;
  logic            r_s1_top_rep, r_s1_flush;

  logic [7:0]      r_lb1 [0:W-1];
  logic [7:0]      r_lb2 [0:W-1];

  logic [9:0]      r_c0, r_c1, r_c2;
  logic            r_s2_emit, r_s2_right, r_s2_final;

  logic [7:0]      r_ext_pix;
  logic            r_ext_pend, r_ext_fin;

  logic [7:0]      w_rd1, w_rd2, w_top, w_bot;
  logic [9:0]      w_col;
  logic [11:0]     w_sum_n, w_sum_r;
  logic [7:0]      w_out_n, w_out_r;
  logic            w_acc00;

  assign w_acc00 = vld_in && (r_state == ST_FILL) && (r_x == X_ZERO) && (r_y == Y_ZERO);

  // Input counters, frame FSM and the input register stage (real or flush pseudo-inputs).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_FILL;
      r_x          <= X_ZERO;
      r_y          <= Y_ZERO;
      r_s1_pix     <= 8'd0;
      r_s1_x       <= X_ZERO;
      r_s1_wr      <= 1'b0;
      r_s1_col     <= 1'b0;
      r_s1_emit    <= 1'b0;
      r_s1_right   <= 1'b0;
      r_s1_final   <= 1'b0;
      r_s1_top_rep <= 1'b0;
      r_s1_flush   <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      r_s1_wr      <= 1'b0;
      r_s1_col     <= 1'b0;
      r_s1_emit    <= 1'b0;
      r_s1_right   <= 1'b0;
      r_s1_final   <= 1'b0;
      r_s1_top_rep <= 1'b0;
      r_s1_flush   <= 1'b0;
      case (r_state)
        ST_FILL: begin
          if (vld_in) begin
            r_s1_wr  <= 1'b1;
            r_s1_pix <= pixel_in;
            r_s1_x   <= r_x;
            if (r_x == X_LAST) begin
              r_x     <= X_ZERO;
              r_y     <= Y_ONE;
              r_state <= ST_RUN;
            end else begin
              r_x <= r_x + X_ONE;
            end
          end
        end
        ST_RUN: begin
          if (vld_in) begin
            r_s1_wr      <= 1'b1;
            r_s1_col     <= 1'b1;
            r_s1_emit    <= (r_x != X_ZERO);
            r_s1_right   <= (r_x == X_LAST);
            r_s1_top_rep <= (r_y == Y_ONE);
            r_s1_pix     <= pixel_in;
            r_s1_x       <= r_x;
            if (r_x == X_LAST) begin
              r_x <= X_ZERO;
              if (r_y == Y_LAST) begin
                r_state <= ST_FLUSH;
              end else begin
                r_y <= r_y + Y_ONE;
              end
            end else begin
              r_x <= r_x + X_ONE;
            end
          end
        end
        ST_FLUSH: begin
          // Input is ignored here; any attempt is recorded as an overflow.
          r_s1_col   <= 1'b1;
          r_s1_flush <= 1'b1;
          r_s1_emit  <= (r_x != X_ZERO);
          r_s1_right <= (r_x == X_LAST);
          r_s1_final <= (r_x == X_LAST);
          r_s1_x     <= r_x;
          if (vld_in) begin
            ovf <= 1'b1;
          end
          if (r_x == X_LAST) begin
            r_x     <= X_ZERO;
            r_y     <= Y_ZERO;
            r_state <= ST_FILL;
          end else begin
            r_x <= r_x + X_ONE;
          end
        end
        default: begin
          r_state <= ST_FILL;
          r_x     <= X_ZERO;
          r_y     <= Y_ZERO;
        end
      endcase
    end
  end

  assign w_rd1 = r_lb1[r_s1_x];
  assign w_rd2 = r_lb2[r_s1_x];

  // Line buffers: read-before-write at one address; lb2 inherits the old lb1 row.
  always_ff @(posedge clk) begin
    if (r_s1_wr) begin
      r_lb1[r_s1_x] <= r_s1_pix;
      r_lb2[r_s1_x] <= w_rd1;
    end
  end

  // Vertical taps with top/bottom replication, folded into one weighted column sum.
  always_comb begin
    w_top = w_rd2;
    w_bot = r_s1_pix;
    if (r_s1_flush) begin
      w_top = w_rd2;
      w_bot = w_rd1;
    end else if (r_s1_top_rep) begin
      w_top = w_rd1;
      w_bot = r_s1_pix;
    end else begin
      w_top = w_rd2;
      w_bot = r_s1_pix;
    end
  end

  assign w_col = {2'b00, w_top} + {1'b0, w_rd1, 1'b0} + {2'b00, w_bot};

  // Column window; column 0 is loaded twice to replicate the left border.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c0       <= 10'd0;
      r_c1       <= 10'd0;
      r_c2       <= 10'd0;
      r_s2_emit  <= 1'b0;
      r_s2_right <= 1'b0;
      r_s2_final <= 1'b0;
    end else begin
      r_s2_emit  <= r_s1_emit;
      r_s2_right <= r_s1_right;
      r_s2_final <= r_s1_final;
      if (r_s1_col) begin
        if (r_s1_x == X_ZERO) begin
          r_c1 <= w_col;
          r_c2 <= w_col;
        end else begin
          r_c0 <= r_c1;
          r_c1 <= r_c2;
          r_c2 <= w_col;
        end
      end
    end
  end

  assign w_sum_n = {2'b00, r_c0} + {1'b0, r_c1, 1'b0} + {2'b00, r_c2};
  assign w_sum_r = {2'b00, r_c1} + {1'b0, r_c2, 1'b0} + {2'b00, r_c2};
  assign w_out_n = 8'((w_sum_n + 12'd8) >> 4);
  assign w_out_r = 8'((w_sum_r + 12'd8) >> 4);

  // Output register; the right-edge result is parked and sent in the following slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_out  <= 8'd0;
      vld_out    <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      r_ext_pix  <= 8'd0;
      r_ext_pend <= 1'b0;
      r_ext_fin  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (r_s2_emit) begin
        pixel_out  <= w_out_n;
        vld_out    <= 1'b1;
        r_ext_pix  <= w_out_r;
        r_ext_pend <= r_s2_right;
        r_ext_fin  <= r_s2_final;
      end else if (r_ext_pend) begin
        pixel_out  <= r_ext_pix;
        vld_out    <= 1'b1;
        frame_done <= r_ext_fin;
        r_ext_pend <= 1'b0;
      end else begin
        vld_out <= 1'b0;
      end
      if (frame_done) begin
        busy <= 1'b0;
      end else if (w_acc00) begin
        busy <= 1'b1;
      end else begin
        busy <= busy;
      end
    end
  end

endmodule

// File: tb/tb_gauss3x3_stream.sv
// Scoreboard bench for gauss3x3_stream: a small 4x3 instance for directed/gap/overflow/reset
// cases and a 430-wide instance for a uniform frame.
module tb_gauss3x3_stream;

  localparam int WA = 4;
  localparam int HA = 3;
  localparam int WB = 430;
  localparam int HB = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] pa_in = 8'd0;
  logic [7:0] pb_in = 8'd0;
  logic       va_in = 1'b0;
  logic       vb_in = 1'b0;
  logic [7:0] pa_out, pb_out;
  logic       va_out, vb_out, fda, fdb, busya, busyb, ovfa, ovfb;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int qa[$];
  int qb[$];
  int vcnt_a = 0;
  int vcnt_b = 0;
  int fdcnt_b = 0;
  int img [0:HA-1][0:WA-1];
  int tab [0:11];
  bit lat_arm = 1'b0;
  int first_cyc = 0;
  int t_acc = 0;

  gauss3x3_stream #(.W(WA), .H(HA)) u_dut_a (
    .clk(clk), .rst(rst), .pixel_in(pa_in), .vld_in(va_in),
    .pixel_out(pa_out), .vld_out(va_out), .frame_done(fda), .busy(busya), .ovf(ovfa)
  );

  gauss3x3_stream #(.W(WB), .H(HB)) u_dut_b (
    .clk(clk), .rst(rst), .pixel_in(pb_in), .vld_in(vb_in),
    .pixel_out(pb_out), .vld_out(vb_out), .frame_done(fdb), .busy(busyb), .ovf(ovfb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference 3x3 Gaussian with clamped coordinates.
  function automatic int gmodel(input int x, input int y);
    int s;
    s = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        int xx;
        int yy;
        xx = x + dx;
        yy = y + dy;
        if (xx < 0) xx = 0;
        if (xx > WA - 1) xx = WA - 1;
        if (yy < 0) yy = 0;
        if (yy > HA - 1) yy = HA - 1;
        s += ((dx == 0) ? 2 : 1) * ((dy == 0) ? 2 : 1) * img[yy][xx];
      end
    end
    return (s + 8) >> 4;
  endfunction

  // Scoreboard for the small instance: entries are {frame_done, pixel}.
  always @(negedge clk) begin
    if (rst) begin
      if (va_out) begin
        vcnt_a++;
        if (lat_arm) begin
          first_cyc = cyc;
          lat_arm = 1'b0;
        end
        if (qa.size() == 0) chk("a_unexpected_out", int'({fda, pa_out}), -1);
        else chk("a_pix", int'({fda, pa_out}), qa.pop_front());
      end else if (fda) begin
        chk("a_fd_without_vld", 1, 0);
      end
    end
  end

  // Scoreboard for the wide instance.
  always @(negedge clk) begin
    if (rst) begin
      if (vb_out) begin
        vcnt_b++;
        if (fdb) fdcnt_b++;
        if (qb.size() == 0) chk("b_unexpected_out", int'({fdb, pb_out}), -1);
        else chk("b_pix", int'({fdb, pb_out}), qb.pop_front());
      end else if (fdb) begin
        chk("b_fd_without_vld", 1, 0);
      end
    end
  end

  task automatic push_tab();
    for (int i = 0; i < WA * HA; i++) qa.push_back(((i == WA * HA - 1) ? 256 : 0) + tab[i]);
  endtask

  task automatic push_model();
    for (int y = 0; y < HA; y++)
      for (int x = 0; x < WA; x++)
        qa.push_back(((y == HA - 1 && x == WA - 1) ? 256 : 0) + gmodel(x, y));
  endtask

  task automatic fill_img(input int mode, input int val);
    for (int y = 0; y < HA; y++)
      for (int x = 0; x < WA; x++)
        img[y][x] = (mode == 0) ? val : int'($urandom_range(255, 0));
  endtask

  task automatic drive_a(input int gap, input bit inj, input int abort_idx, input bit lat);
    vcnt_a = 0;
    for (int y = 0; y < HA; y++) begin
      for (int x = 0; x < WA; x++) begin
        while (gap > 0 && $urandom_range(99, 0) < gap) begin
          va_in = 1'b0;
          @(posedge clk); #1;
        end
        va_in = 1'b1;
        pa_in = 8'(img[y][x]);
        if (lat && x == 1 && y == 1) begin
          t_acc = cyc + 1;
          lat_arm = 1'b1;
        end
        @(posedge clk); #1;
        if (y == 1 && x == 0) chk("busy_mid_frame", int'(busya), 1);
        if (abort_idx == y * WA + x) begin
          va_in = 1'b0;
          #2;
          rst = 1'b0;
          qa.delete();
          #1;
          chk("rst_pixel_out", int'(pa_out), 0);
          chk("rst_vld_out", int'(va_out), 0);
          chk("rst_busy", int'(busya), 0);
          @(posedge clk); #3;
          rst = 1'b1;
          return;
        end
      end
    end
    va_in = 1'b0;
    if (inj) begin
      @(posedge clk); #1;
      va_in = 1'b1;
      pa_in = 8'hAA;
      @(posedge clk); #1;
      va_in = 1'b0;
    end
  endtask

  task automatic wait_a();
    for (int i = 0; i < 200; i++) begin
      if (qa.size() == 0 && !busya) break;
      @(posedge clk); #1;
    end
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("a_queue_drained", qa.size(), 0);
    chk("a_busy_idle", int'(busya), 0);
  endtask

  initial begin
    #12;
    chk("reset_pixel_out", int'(pa_out), 0);
    chk("reset_vld_out", int'(va_out), 0);
    chk("reset_frame_done", int'(fda), 0);
    chk("reset_busy", int'(busya), 0);
    chk("reset_ovf", int'(ovfa), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Uniform wide frame: every output equals the input level.
    vcnt_b = 0;
    fdcnt_b = 0;
    for (int i = 0; i < WB * HB; i++) qb.push_back(((i == WB * HB - 1) ? 256 : 0) + 100);
    for (int i = 0; i < WB * HB; i++) begin
      vb_in = 1'b1;
      pb_in = 8'd100;
      @(posedge clk); #1;
      if (i == 0) chk("b_busy_rise", int'(busyb), 1);
    end
    vb_in = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (qb.size() == 0 && !busyb) break;
      @(posedge clk); #1;
    end
    chk("b_queue_drained", qb.size(), 0);
    chk("b_vld_count", vcnt_b, WB * HB);
    chk("b_frame_done_count", fdcnt_b, 1);
    chk("b_ovf", int'(ovfb), 0);
    chk("b_busy_idle", int'(busyb), 0);

    // Single bright pixel at (1,1), with latency check.
    fill_img(0, 0);
    img[1][1] = 255;
    tab = '{16, 32, 16, 0, 32, 64, 32, 0, 16, 32, 16, 0};
    push_tab();
    drive_a(0, 1'b0, -1, 1'b1);
    wait_a();
    chk("latency_first_out", first_cyc, t_acc + 2);
    chk("t2_vld_count", vcnt_a, 12);
    chk("t2_ovf", int'(ovfa), 0);

    // Corner pixel exercises left/top replication.
    fill_img(0, 0);
    img[0][0] = 255;
    tab = '{143, 48, 0, 0, 48, 16, 0, 0, 0, 0, 0, 0};
    push_tab();
    drive_a(0, 1'b0, -1, 1'b0);
    wait_a();
    chk("t3_vld_count", vcnt_a, 12);

    // Same image as the single-pixel case, with random idle gaps.
    fill_img(0, 0);
    img[1][1] = 255;
    tab = '{16, 32, 16, 0, 32, 64, 32, 0, 16, 32, 16, 0};
    push_tab();
    drive_a(30, 1'b0, -1, 1'b0);
    wait_a();
    chk("t4_vld_count", vcnt_a, 12);

    // Input during flush sets sticky ovf without disturbing the frame.
    fill_img(1, 0);
    push_model();
    drive_a(0, 1'b1, -1, 1'b0);
    wait_a();
    chk("t5_ovf_set", int'(ovfa), 1);
    chk("t5_vld_count", vcnt_a, 12);
    fill_img(1, 0);
    push_model();
    drive_a(20, 1'b0, -1, 1'b0);
    wait_a();
    chk("t5_ovf_sticky", int'(ovfa), 1);
    chk("t5_next_vld_count", vcnt_a, 12);

    // Asynchronous reset in row 2, then a fresh uniform frame.
    fill_img(0, 77);
    push_model();
    drive_a(0, 1'b0, 9, 1'b0);
    chk("t6_ovf_cleared", int'(ovfa), 0);
    fill_img(0, 50);
    push_model();
    drive_a(0, 1'b0, -1, 1'b0);
    wait_a();
    chk("t6_vld_count", vcnt_a, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
